// File: rtl/l2_input_fifo_pkg.sv
// -----------------------------------------------------------------------------
// l2_input_fifo_pkg
// Shared types for the L2 input elastic buffer.
//   fifo_op_e : encoding of the per-cycle handshake activity (push/pop).
//   fifo_op() : folds the push and pop strobes into a fifo_op_e.
// No ports; imported by l2_input_fifo.
// -----------------------------------------------------------------------------
package l2_input_fifo_pkg;

  // Bit 1 = push, bit 0 = pop, so the enum can be built by concatenation.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/l2_input_fifo_mem.sv
// -----------------------------------------------------------------------------
// l2_input_fifo_mem
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous
// read port. Contents are never reset.
// Ports:
//   clk      in             clock
//   wr_en    in             write strobe
//   wr_addr  in  ADDR_W     write address
//   wr_data  in  DATA_W     write payload
//   rd_addr  in  ADDR_W     read address
//   rd_data  out DATA_W     mem[rd_addr], combinational
// -----------------------------------------------------------------------------
module l2_input_fifo_mem #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/l2_input_fifo.sv
// -----------------------------------------------------------------------------
// l2_input_fifo
// Per-channel elastic buffer between an L2 external interface and the L2 input
// decoder. Absorbs traffic while the decoder is stalled and presents a
// registered valid/payload pair. in_ready depends on registered state (plus
// rst/clear) only, so there is no combinational path out_ready -> in_ready.
//
// Configuration macro: L2_INPUT_FIFO_BYPASS_EN
//   defined   : empty-buffer bypass; when count == 0 an arriving beat is
//               shown on out_valid/out_data in the same cycle.
//   undefined : minimum latency of one cycle.
//
// Ports:
//   clk          in             clock, posedge
//   rst          in             synchronous active-high reset
//   clear        in             synchronous flush (drops all entries)
//   in_valid     in             producer has payload
//   in_ready     out            buffer accepts payload this cycle
//   in_data      in  DATA_W     producer payload
//   out_valid    out            payload available to the decoder
//   out_ready    in             decoder consumes payload
//   out_data     out DATA_W     head payload
//   count        out CNT_W      occupancy
//   almost_full  out            count >= AF_LEVEL
// -----------------------------------------------------------------------------
module l2_input_fifo
  import l2_input_fifo_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 2,
  parameter int AF_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] head_data;
  logic              empty;
  logic              push;
  logic              pop;
  fifo_op_e          op;

  // Handshake: a beat moves on a port in any cycle where that port's valid
  // and ready are both high at the rising edge. valid never waits on ready,
  // and a presented beat stays stable until it is taken.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign op   = fifo_op(push, pop);

  assign empty    = (count_q == '0);
  assign in_ready = !rst && !clear && (count_q != CNT_W'(DEPTH));

`ifdef L2_INPUT_FIFO_BYPASS_EN
  // An empty buffer forwards the arriving beat directly. If it is consumed,
  // push and pop fire together: both pointers advance past the written slot
  // and count is unchanged, which is exactly a zero-latency pass-through.
  assign out_valid = !empty || in_valid;
  assign out_data  = empty ? in_data : head_data;
`else
  assign out_valid = !empty;
  assign out_data  = head_data;
`endif

  assign count       = count_q;
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

  l2_input_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

  // rst and clear both flush; push is already blocked via in_ready, and the
  // flush branch overrides any concurrent pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case (op)
        OP_PUSH: count_q <= count_q + 1'b1;
        OP_POP:  count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_input_fifo.sv
// -----------------------------------------------------------------------------
// tb_l2_input_fifo
// Directed bench for l2_input_fifo at DEPTH=2, DATA_W=8, AF_LEVEL=1.
// Inputs change 2 time units after each rising edge; directed checks run at
// that point, and the scoreboard samples handshakes on the falling edge.
// -----------------------------------------------------------------------------
module tb_l2_input_fifo;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 2;
  localparam int AF_LEVEL = 1;
`ifdef L2_INPUT_FIFO_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;
  logic              almost_full;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int pop_cnt  = 0;
  int pops_before;

  logic [DATA_W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b0;
  end

  l2_input_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // scoreboard: record accepted beats, compare every consumed beat in order
  always @(negedge clk) begin
    if (rst || clear) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          fail_cnt++;
          $error("FAIL sb_underflow observed=%0h expected=none", out_data);
        end else begin
          chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // reset held 3 cycles with in_valid high
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'(BYP));
      chk("rst_count", 32'(count), 32'd0);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_af", 32'(almost_full), 32'd0);

    // latency and order
    drive(1'b1, 8'hA1, 1'b0);
    cyc();
    chk("lat_count1", 32'(count), 32'd1);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_data", 32'(out_data), 32'hA1);
    chk("lat_af", 32'(almost_full), 32'd1);
    drive(1'b1, 8'hB2, 1'b0);
    cyc();
    chk("lat_count2", 32'(count), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'(out_data), 32'hA1);
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    chk("hold_head", 32'(out_data), 32'hA1);
    chk("hold_count", 32'(count), 32'd2);
    drive(1'b0, 8'h00, 1'b1);
    cyc();
    chk("drain_b2", 32'(out_data), 32'hB2);
    chk("drain_count1", 32'(count), 32'd1);
    cyc();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_count0", 32'(count), 32'd0);
    chk("drain_af", 32'(almost_full), 32'd0);

    // full with simultaneous pop
    drive(1'b1, 8'h11, 1'b0);
    cyc();
    drive(1'b1, 8'h22, 1'b0);
    cyc();
    chk("fp_full", 32'(count), 32'd2);
    drive(1'b1, 8'hC3, 1'b1);
    cyc();
    chk("fp_pop_only", 32'(count), 32'd1);
    chk("fp_head", 32'(out_data), 32'h22);
    chk("fp_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("fp_c3_count", 32'(count), 32'd1);
    chk("fp_c3_head", 32'(out_data), 32'hC3);
    drive(1'b0, 8'h00, 1'b1);
    cyc();
    chk("fp_empty", 32'(count), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    cyc();

    // wrap-around stream
    pops_before = pop_cnt;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      cyc();
      chk("wrap_count", 32'(count), BYP ? 32'd0 : 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1);
    cyc();
    cyc();
    chk("wrap_final_count", 32'(count), 32'd0);
    chk("wrap_pops", 32'(pop_cnt - pops_before), 32'd16);
    drive(1'b0, 8'h00, 1'b0);
    cyc();

    // clear with count == 2 and a concurrent beat
    drive(1'b1, 8'h31, 1'b0);
    cyc();
    drive(1'b1, 8'h42, 1'b0);
    cyc();
    chk("clr_pre_count", 32'(count), 32'd2);
    clear = 1'b1;
    drive(1'b1, 8'hD4, 1'b0);
    cyc();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    clear = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_count_after", 32'(count), 32'd0);
    drive(1'b1, 8'hE7, 1'b0);
    cyc();
    chk("clr_refill_data", 32'(out_data), 32'hE7);
    chk("clr_refill_count", 32'(count), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    cyc();
    chk("clr_refill_drain", 32'(count), 32'd0);

    // empty buffer meeting a beat with out_ready high
    drive(1'b1, 8'hE5, 1'b1);
    #1;
`ifdef L2_INPUT_FIFO_BYPASS_EN
    chk("byp_out_valid", 32'(out_valid), 32'd1);
    chk("byp_out_data", 32'(out_data), 32'hE5);
    cyc();
    chk("byp_count", 32'(count), 32'd0);
    drive(1'b1, 8'hE5, 1'b0);
    cyc();
    chk("byp_push_count", 32'(count), 32'd1);
    chk("byp_push_data", 32'(out_data), 32'hE5);
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    chk("byp_hold_data", 32'(out_data), 32'hE5);
`else
    chk("nobyp_out_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("nobyp_count", 32'(count), 32'd1);
    chk("nobyp_data", 32'(out_data), 32'hE5);
`endif
    drive(1'b0, 8'h00, 1'b1);
    cyc();
    chk("end_count", 32'(count), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/l2_input_fifo.md
# l2_input_fifo

Per-channel elastic buffer between the L2 external interfaces (CPU request, NoC forward, NoC response) and the L2 input decoder. Each channel instantiates one copy. The copy absorbs input traffic while the decoder is busy, stalled on MSHR count, or evict-stalled, and presents a registered valid/payload pair on the decoder's `l2_*_valid_int` / `l2_*_ready_int` handshake. The block decouples external ready from decoder arbitration, so no combinational path exists from `out_ready` to `in_ready`.

## Interface
Parameters:
- `DATA_W`, 64: payload width (packed channel struct).
- `DEPTH`, 2: number of entries; power of two, ≥ 2.
- `AF_LEVEL`, 1: `almost_full` threshold; 1 ≤ AF_LEVEL ≤ DEPTH.

Ports:
- `clk`, in, 1: clock; all logic on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `clear`, in, 1: synchronous flush; drops all entries.
- `in_valid`, in, 1: external producer has payload.
- `in_ready`, out, 1: buffer accepts payload this cycle.
- `in_data`, in, DATA_W: external payload.
- `out_valid`, out, 1: payload available to the decoder (`l2_*_valid_int`).
- `out_ready`, in, 1: decoder consumes the payload (`l2_*_ready_int`).
- `out_data`, out, DATA_W: head payload.
- `count`, out, $clog2(DEPTH)+1: current occupancy.
- `almost_full`, out, 1: `count >= AF_LEVEL`.

## Operation
- Circular buffer. State:
  - `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
  - `count` register.
- Handshake events:
  - push = `in_valid && in_ready`.
  - pop = `out_valid && out_ready`.
  - Push writes `mem[wr_ptr]` and increments `wr_ptr`.
  - Pop increments `rd_ptr`.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- `in_ready = !rst && !clear && (count != DEPTH)`. This depends on registered state only.
- `out_valid = (count != 0)`. `out_data = mem[rd_ptr]`. Neither depends on `out_ready`.
- Full (count == DEPTH): `in_ready` = 0, so no push. A pop in the same cycle frees a slot, but the slot is not visible to `in_ready` until the next cycle.
- Empty (count == 0): `out_valid` = 0, so `out_ready` is ignored.
- Payload hold: while `out_valid && !out_ready`, `out_data` is held stable.
- `clear` has priority over push and pop. It zeroes `count`, `wr_ptr` and `rd_ptr`, and any concurrent `in_valid` is not accepted.
- `rst` behaves like `clear` and also takes precedence over it.
- Memory contents are not reset.

## Timing
- Reset values:
  - `count` = 0, `out_valid` = 0, `almost_full` = 0 (AF_LEVEL ≥ 1).
  - `in_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` falls.
  - `out_data` is undefined until the first push.
- Latency, baseline: data pushed in cycle N is visible on `out_valid`/`out_data` in cycle N+1.
- Throughput: one push and one pop per cycle sustained when DEPTH ≥ 2.
- `count` and `almost_full` reflect state after the previous edge.

## Configuration
- `L2_INPUT_FIFO_BYPASS_EN`, defined: empty-buffer bypass.
  - When count == 0 and `in_valid`, drive `out_valid` = 1 and `out_data` = `in_data` combinationally.
  - If `out_ready` is also high, the beat passes through with zero latency and `count` does not change.
  - Otherwise the beat is written as a normal push.
  - `in_ready` remains count-based, so no combinational loop is formed.
- Undefined: no bypass; minimum latency is 1 cycle as described under Timing.

## Structure
- In `spandex_types.svh`: packed payload typedefs `l2_cpu_req_pkt_t`, `l2_fwd_in_pkt_t`, `l2_rsp_in_pkt_t`. Their `$bits` value sets `DATA_W` at each instantiation.
- In `spandex_consts.svh`: the constants `L2_CPU_REQ_FIFO_DEPTH`, `L2_FWD_IN_FIFO_DEPTH`, `L2_RSP_IN_FIFO_DEPTH`.
- Sub-module `l2_input_fifo_mem`: DEPTH×DATA_W register array with one synchronous write port and one asynchronous read port, no reset. Pointer, count and handshake logic stay in `l2_input_fifo`.

## Test plan
All scenarios use DEPTH=2, DATA_W=8, AF_LEVEL=1, bypass off unless stated.
- Reset: hold `rst` 3 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `count`=0 throughout. After release, `in_ready`=1 next cycle.
- Latency and order: push 0xA1, 0xB2 back-to-back with `out_ready`=0 → `count` 1 then 2, `in_ready`=0, `almost_full`=1, `out_data`=0xA1 held. Raise `out_ready` → 0xA1 then 0xB2, then `out_valid`=0.
- Full with simultaneous pop: hold full, then assert `in_valid` (0xC3) and `out_ready` together → pop only, `count`=1. Next cycle 0xC3 is accepted, `count` stays 1.
- Wrap-around: stream 0x00..0x0F with `out_ready`=1 and `in_valid`=1 continuously → every value appears in order with no drops, and the pointers wrap 8 times.
- Clear: with `count`=2, pulse `clear` while `in_valid`=1 (0xD4) → `count`=0, 0xD4 is not accepted, and `out_valid`=0 next cycle.
- Bypass (`L2_INPUT_FIFO_BYPASS_EN` defined): empty buffer, `in_valid`=1 0xE5, `out_ready`=1 → `out_data`=0xE5 in the same cycle and `count` stays 0. Repeat with `out_ready`=0 → `count`=1 and `out_data` holds 0xE5.
